// File: rtl/znmi_retn.sv
// Z80 opcode-stream sniffer: detects NMI acceptance and RETN/RETI fetches,
// pulses clr_nmi on RETN and tracks NMI nesting depth.
module znmi_retn #(
  parameter logic [15:0] NMI_VEC = 16'h0066,
  parameter int          DEPTH_W = 2
) (
  input  logic               fclk,
  input  logic               rst,
  input  logic               zpos,
  input  logic               zneg,
  input  logic               m1_n,
  input  logic               mreq_n,
  input  logic               iorq_n,
  input  logic               rfsh_n,
  input  logic [15:0]        a,
  input  logic [7:0]         d,
  input  logic               gen_nmi,
  output logic               nmi_ack,
  output logic               retn_seen,
  output logic               reti_seen,
  output logic               clr_nmi,
  output logic [DEPTH_W-1:0] depth,
  output logic               in_handler
);

  typedef enum logic {IDLE, ED_SEEN} state_t;

  state_t             state_q, state_d;
  logic               m1_q, m1_d;
  logic               mreq_q, mreq_d;
  logic               iorq_q, iorq_d;
  logic               rfsh_q, rfsh_d;
  logic               rfsh_dly_q, rfsh_dly_d;
  logic [7:0]         opc_q, opc_d;
  logic [15:0]        adr_q, adr_d;
  logic               fetched_q, fetched_d;
  logic               nmi_seen_q, nmi_seen_d;
  logic               nmi_ack_q, nmi_ack_d;
  logic               retn_q, retn_d;
  logic               reti_q, reti_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;

  logic opc_fetch;
  logic fd;
  logic qual_fd;
  logic is_retn;

  // Interrupt-acknowledge M1 cycles carry IORQ low and are not opcode fetches.
  assign opc_fetch = ~m1_q & ~mreq_q & iorq_q;
  assign fd        = rfsh_dly_q & ~rfsh_q;
  assign qual_fd   = fd & fetched_q;

  always_comb begin
    is_retn = 1'b0;
    case (opc_q)
      8'h45, 8'h55, 8'h5D, 8'h65, 8'h6D, 8'h75, 8'h7D: is_retn = 1'b1;
      default: is_retn = 1'b0;
    endcase
  end

  always_comb begin
    m1_d       = zneg ? m1_n   : m1_q;
    mreq_d     = zneg ? mreq_n : mreq_q;
    iorq_d     = zneg ? iorq_n : iorq_q;
    rfsh_d     = zpos ? rfsh_n : rfsh_q;
    rfsh_dly_d = rfsh_q;
    opc_d      = (opc_fetch && zpos) ? d : opc_q;
    adr_d      = (opc_fetch && zpos) ? a : adr_q;
    fetched_d  = fd ? 1'b0 : (fetched_q | opc_fetch);
    nmi_seen_d = fd ? 1'b0 : (nmi_seen_q | (opc_fetch & zpos & gen_nmi));
    state_d    = state_q;
    nmi_ack_d  = 1'b0;
    retn_d     = 1'b0;
    reti_d     = 1'b0;
    depth_d    = depth_q;

    // NMI acceptance takes priority and abandons any pending ED prefix.
    if (qual_fd) begin
      if (adr_q == NMI_VEC && nmi_seen_q) begin
        nmi_ack_d = 1'b1;
        state_d   = IDLE;
        if (depth_q != '1) depth_d = depth_q + DEPTH_W'(1);
      end else begin
        case (state_q)
          IDLE: begin
            if (opc_q == 8'hED) state_d = ED_SEEN;
          end
          ED_SEEN: begin
            state_d = IDLE;
            if (is_retn) begin
              retn_d = 1'b1;
              if (depth_q != '0) depth_d = depth_q - DEPTH_W'(1);
            end else if (opc_q == 8'h4D) begin
              reti_d = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      m1_q       <= 1'b1;
      mreq_q     <= 1'b1;
      iorq_q     <= 1'b1;
      rfsh_q     <= 1'b1;
      rfsh_dly_q <= 1'b1;
      opc_q      <= 8'h00;
      adr_q      <= 16'h0000;
      fetched_q  <= 1'b0;
      nmi_seen_q <= 1'b0;
      nmi_ack_q  <= 1'b0;
      retn_q     <= 1'b0;
      reti_q     <= 1'b0;
      depth_q    <= '0;
    end else begin
      state_q    <= state_d;
      m1_q       <= m1_d;
      mreq_q     <= mreq_d;
      iorq_q     <= iorq_d;
      rfsh_q     <= rfsh_d;
      rfsh_dly_q <= rfsh_dly_d;
      opc_q      <= opc_d;
      adr_q      <= adr_d;
      fetched_q  <= fetched_d;
      nmi_seen_q <= nmi_seen_d;
      nmi_ack_q  <= nmi_ack_d;
      retn_q     <= retn_d;
      reti_q     <= reti_d;
      depth_q    <= depth_d;
    end
  end

  assign nmi_ack    = nmi_ack_q;
  assign retn_seen  = retn_q;
  assign reti_seen  = reti_q;
  assign clr_nmi    = retn_q;
  assign depth      = depth_q;
  assign in_handler = (depth_q != '0);

endmodule

// File: tb/tb_znmi_retn.sv
// Scoreboard bench for znmi_retn: directed Z80 fetch sequences push expected
// pulses; a monitor pops and compares whenever any pulse output is high.
module tb_znmi_retn;

  logic        fclk;
  logic        rst;
  logic        zpos;
  logic        zneg;
  logic        m1_n;
  logic        mreq_n;
  logic        iorq_n;
  logic        rfsh_n;
  logic [15:0] a;
  logic [7:0]  d;
  logic        gen_nmi;
  logic        nmi_ack;
  logic        retn_seen;
  logic        reti_seen;
  logic        clr_nmi;
  logic [1:0]  depth;
  logic        in_handler;

  logic [1:0]  phase;

  typedef struct {
    logic     ack;
    logic     retn;
    logic     reti;
    int       dep;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   model_depth;

  znmi_retn #(.NMI_VEC(16'h0066), .DEPTH_W(2)) dut (
    .fclk      (fclk),
    .rst       (rst),
    .zpos      (zpos),
    .zneg      (zneg),
    .m1_n      (m1_n),
    .mreq_n    (mreq_n),
    .iorq_n    (iorq_n),
    .rfsh_n    (rfsh_n),
    .a         (a),
    .d         (d),
    .gen_nmi   (gen_nmi),
    .nmi_ack   (nmi_ack),
    .retn_seen (retn_seen),
    .reti_seen (reti_seen),
    .clr_nmi   (clr_nmi),
    .depth     (depth),
    .in_handler(in_handler)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  // Z80 clock is fclk/4: rising-edge strobe at phase 0, falling at phase 2.
  initial phase = 2'd0;
  always @(posedge fclk) phase <= phase + 2'd1;
  assign zpos = (phase == 2'd0);
  assign zneg = (phase == 2'd2);

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Pulses are checked against the scoreboard head; any extra cycle of pulse
  // finds either an empty queue or the wrong entry.
  always @(negedge fclk) begin
    if (!rst && (nmi_ack || retn_seen || reti_seen || clr_nmi)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse: got ack=%0d retn=%0d reti=%0d clr=%0d expected none",
                 nmi_ack, retn_seen, reti_seen, clr_nmi);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("pulse_ack",  int'(nmi_ack),   int'(e.ack));
        checkOutput("pulse_retn", int'(retn_seen), int'(e.retn));
        checkOutput("pulse_reti", int'(reti_seen), int'(e.reti));
        checkOutput("pulse_clr",  int'(clr_nmi),   int'(e.retn));
        checkOutput("pulse_depth", int'(depth),    e.dep);
      end
    end
  end

  task automatic expectPulse(input logic ack, input logic retn, input logic reti);
    exp_t e;
    if (ack && model_depth < 3) model_depth++;
    if (retn && model_depth > 0) model_depth--;
    e.ack  = ack;
    e.retn = retn;
    e.reti = reti;
    e.dep  = model_depth;
    exp_q.push_back(e);
  endtask

  // One M1 cycle followed by refresh; iack makes it an interrupt-acknowledge.
  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] opc, input logic iack);
    @(negedge fclk);
    a      = addr;
    d      = opc;
    m1_n   = 1'b0;
    mreq_n = iack ? 1'b1 : 1'b0;
    iorq_n = iack ? 1'b0 : 1'b1;
    rfsh_n = 1'b1;
    repeat (8) @(negedge fclk);
    m1_n   = 1'b1;
    mreq_n = 1'b1;
    iorq_n = 1'b1;
    rfsh_n = 1'b0;
    repeat (8) @(negedge fclk);
    rfsh_n = 1'b1;
    repeat (4) @(negedge fclk);
  endtask

  task automatic checkState(input string name);
    checkOutput({name, "_depth"},      int'(depth),      model_depth);
    checkOutput({name, "_in_handler"}, int'(in_handler), int'(model_depth != 0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    model_depth = 0;
    rst     = 1'b1;
    m1_n    = 1'b1;
    mreq_n  = 1'b1;
    iorq_n  = 1'b1;
    rfsh_n  = 1'b1;
    a       = 16'h0000;
    d       = 8'h00;
    gen_nmi = 1'b0;
    repeat (3) @(negedge fclk);
    checkOutput("reset_nmi_ack", int'(nmi_ack),   0);
    checkOutput("reset_retn",    int'(retn_seen), 0);
    checkOutput("reset_reti",    int'(reti_seen), 0);
    checkOutput("reset_clr",     int'(clr_nmi),   0);
    checkState("reset");
    rst = 1'b0;
    repeat (4) @(negedge fclk);

    // Four NMI acknowledges: depth 1, 2, 3, then saturates at 3.
    gen_nmi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expectPulse(1'b1, 1'b0, 1'b0);
      applyStimulus(16'h0066, 8'hF5, 1'b0);
      checkState("nmi_ack");
    end
    gen_nmi = 1'b0;

    // ED 45 -> RETN, depth 3 -> 2.
    applyStimulus(16'h8000, 8'hED, 1'b0);
    expectPulse(1'b0, 1'b1, 1'b0);
    applyStimulus(16'h8001, 8'h45, 1'b0);
    checkState("retn_ed45");

    // ED 4D -> RETI only, depth unchanged.
    applyStimulus(16'h8002, 8'hED, 1'b0);
    expectPulse(1'b0, 1'b0, 1'b1);
    applyStimulus(16'h8003, 8'h4D, 1'b0);
    checkState("reti_ed4d");

    // ED ED 45 -> second ED consumed, 45 decoded in IDLE: no pulse.
    applyStimulus(16'h8004, 8'hED, 1'b0);
    applyStimulus(16'h8005, 8'hED, 1'b0);
    applyStimulus(16'h8006, 8'h45, 1'b0);
    checkState("ed_ed_45");

    // DD ED 55 -> RETN, depth 2 -> 1.
    applyStimulus(16'h8007, 8'hDD, 1'b0);
    applyStimulus(16'h8008, 8'hED, 1'b0);
    expectPulse(1'b0, 1'b1, 1'b0);
    applyStimulus(16'h8009, 8'h55, 1'b0);
    checkState("dd_ed_55");

    // ED, interrupt-ack cycle, 45 -> RETN, depth 1 -> 0.
    applyStimulus(16'h800A, 8'hED, 1'b0);
    applyStimulus(16'h1234, 8'hFF, 1'b1);
    expectPulse(1'b0, 1'b1, 1'b0);
    applyStimulus(16'h800B, 8'h45, 1'b0);
    checkState("ed_iack_45");

    // Fetch at NMI vector without NMI: no acknowledge.
    applyStimulus(16'h0066, 8'hF5, 1'b0);
    checkState("vec_no_nmi");

    // ED 7D at depth 0 still pulses clr_nmi, depth stays 0.
    applyStimulus(16'h800C, 8'hED, 1'b0);
    expectPulse(1'b0, 1'b1, 1'b0);
    applyStimulus(16'h800D, 8'h7D, 1'b0);
    checkState("retn_depth0");

    // ED then NMI acknowledge drops the prefix: following 45 gives nothing.
    applyStimulus(16'h800E, 8'hED, 1'b0);
    gen_nmi = 1'b1;
    expectPulse(1'b1, 1'b0, 1'b0);
    applyStimulus(16'h0066, 8'hF5, 1'b0);
    gen_nmi = 1'b0;
    applyStimulus(16'h0067, 8'h45, 1'b0);
    checkState("ack_clears_ed");

    // Reset between ED and 45: outputs clear at once, prefix is lost.
    applyStimulus(16'h8010, 8'hED, 1'b0);
    @(negedge fclk);
    rst = 1'b1;
    #1;
    model_depth = 0;
    checkOutput("rst_mid_depth",      int'(depth),      0);
    checkOutput("rst_mid_in_handler", int'(in_handler), 0);
    checkOutput("rst_mid_retn",       int'(retn_seen),  0);
    repeat (3) @(negedge fclk);
    rst = 1'b0;
    repeat (4) @(negedge fclk);
    applyStimulus(16'h8011, 8'h45, 1'b0);
    checkState("after_rst_45");

    repeat (8) @(negedge fclk);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
